// File: rtl/xnor_col_accum_if.sv
// Handshake bundle between the column bit-plane driver and the accumulator.
// The driver side presents planes. The accumulator side returns the result and status.
interface xnor_col_accum_if #(
  parameter int N_CELLS = 16,
  parameter int IN_BITS = 8,
  parameter int PC_W    = $clog2(N_CELLS + 1),
  parameter int ACC_W   = PC_W + IN_BITS + 1
);
  logic               start;
  logic               in_valid;
  logic               wl;
  logic [N_CELLS-1:0] vout;
  logic               busy;
  logic               out_valid;
  logic [ACC_W-1:0]   acc_out;
  logic               err;

  modport master (
    output start, in_valid, wl, vout,
    input  busy, out_valid, acc_out, err
  );

  modport slave (
    input  start, in_valid, wl, vout,
    output busy, out_valid, acc_out, err
  );
endinterface

// File: rtl/xnor_col_accum.sv
// Column-side bit-serial accumulator for the XNOR CIM array.
// Each accepted bit-plane is popcounted, and the popcount is registered.
// One cycle later the popcount is shift-accumulated MSB-first into a signed partial sum.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; in_valid ignored; result held
//   ACCUM | accepting planes (in_valid & !wl); last plane moves to FLUSH
//   FLUSH | final popcount accumulates on exit; out_valid follows
module xnor_col_accum #(
  parameter int N_CELLS   = 16,
  parameter int IN_BITS   = 8,
  parameter int SIGNED_IN = 1,
  parameter int PC_W      = $clog2(N_CELLS + 1),
  parameter int ACC_W     = PC_W + IN_BITS + 1
) (
  input logic              clk,
  input logic              rst,
  xnor_col_accum_if.slave  bus
);
  localparam int CNT_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(IN_BITS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [PC_W-1:0]          pc, pc_r;
  logic                     stg_v, stg_first;
  logic signed [ACC_W-1:0]  acc, acc_nxt, pc_ext;
  logic                     err_r, out_valid_r, busy;
  logic                     start_ok, accept, collide, last;

  assign start_ok = (state == IDLE) && bus.start;
  assign accept   = (state == ACCUM) && bus.in_valid && !bus.wl;
  assign collide  = (state == ACCUM) && bus.in_valid && bus.wl;
  assign last     = (cnt == LAST_PLANE);

  // Popcount of the current column vector.
  always_comb begin
    pc = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      pc = pc + PC_W'(bus.vout[i]);
    end
  end

  // Accumulate step. The MSB plane seeds the sum and carries negative weight in signed mode.
  always_comb begin
    pc_ext = $signed({{(ACC_W - PC_W){1'b0}}, pc_r});
    if (stg_first) begin
      acc_nxt = (SIGNED_IN != 0) ? -pc_ext : pc_ext;
    end else begin
      acc_nxt = (acc <<< 1) + pc_ext;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)      state_nxt = ACCUM;
      ACCUM:   if (accept && last) state_nxt = FLUSH;
      FLUSH:                       state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: popcount register, plane counter, accumulator, sticky error, done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      pc_r        <= '0;
      stg_v       <= 1'b0;
      stg_first   <= 1'b0;
      acc         <= '0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state == FLUSH);
      stg_v       <= accept;
      stg_first   <= accept && (cnt == '0);
      if (accept) begin
        pc_r <= pc;
      end
      if (start_ok) begin
        cnt   <= '0;
        acc   <= '0;
        err_r <= 1'b0;
      end else begin
        if (accept) cnt <= last ? '0 : cnt + 1'b1;
        if (stg_v)  acc <= acc_nxt;
        if (collide) err_r <= 1'b1;
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.out_valid = out_valid_r;
  assign bus.acc_out   = acc;
  assign bus.err       = err_r;
endmodule

// File: tb/tb_xnor_col_accum.sv
// Directed bench: an unsigned and a signed instance receive the same plane stream.
module tb_xnor_col_accum;
  localparam int NC = 16;
  localparam int IB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  xnor_col_accum_if #(.N_CELLS(NC), .IN_BITS(IB)) bus_u ();
  xnor_col_accum_if #(.N_CELLS(NC), .IN_BITS(IB)) bus_s ();

  assign bus_s.start    = bus_u.start;
  assign bus_s.in_valid = bus_u.in_valid;
  assign bus_s.wl       = bus_u.wl;
  assign bus_s.vout     = bus_u.vout;

  xnor_col_accum #(.N_CELLS(NC), .IN_BITS(IB), .SIGNED_IN(0)) dut_u (
    .clk (clk), .rst (rst), .bus (bus_u.slave));
  xnor_col_accum #(.N_CELLS(NC), .IN_BITS(IB), .SIGNED_IN(1)) dut_s (
    .clk (clk), .rst (rst), .bus (bus_s.slave));

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int acc_u();
    return int'($signed(bus_u.acc_out));
  endfunction

  function automatic int acc_s();
    return int'($signed(bus_s.acc_out));
  endfunction

  // Drive one cycle of inputs from a negedge; return at the following negedge.
  task automatic cyc(input logic st, input logic iv, input logic w, input logic [NC-1:0] v);
    bus_u.start    = st;
    bus_u.in_valid = iv;
    bus_u.wl       = w;
    bus_u.vout     = v;
    @(negedge clk);
  endtask

  // One full operation. wl_plane < 0 means no collision. start_plane < 0 means no stray start.
  task automatic run_op(input string tag, input logic [NC-1:0] p [IB], input int gap,
                        input int wl_plane, input int start_plane, input bit skip_start,
                        input bit chain, input int exp_u, input int exp_s);
    int ncyc;
    ncyc = 0;
    if (!skip_start) begin
      cyc(1'b1, 1'b0, 1'b0, '0);
      check({tag, " busy after start"}, int'(bus_u.busy), 1);
      check({tag, " err cleared"}, int'(bus_u.err), 0);
    end
    for (int i = 0; i < IB; i++) begin
      if (i == wl_plane) begin
        cyc(1'b0, 1'b1, 1'b1, p[i]);
        ncyc++;
        check({tag, " err on wl"}, int'(bus_u.err), 1);
      end
      cyc((i == start_plane), 1'b1, 1'b0, p[i]);
      ncyc++;
      check({tag, " no early out_valid"}, int'(bus_u.out_valid), 0);
      if (i < IB - 1) begin
        for (int g = 0; g < gap; g++) begin
          cyc(1'b0, 1'b0, 1'b0, '0);
          ncyc++;
          check({tag, " busy in gap"}, int'(bus_u.busy), 1);
          check({tag, " no out_valid in gap"}, int'(bus_u.out_valid), 0);
        end
      end
    end
    cyc(1'b0, 1'b0, 1'b0, '0);
    ncyc++;
    check({tag, " out_valid"}, int'(bus_u.out_valid), 1);
    check({tag, " latency"}, ncyc, IB + 1 + (IB - 1) * gap + ((wl_plane >= 0) ? 1 : 0));
    check({tag, " acc unsigned"}, acc_u(), exp_u);
    check({tag, " acc signed"}, acc_s(), exp_s);
    check({tag, " busy dropped"}, int'(bus_u.busy), 0);
    check({tag, " err sticky"}, int'(bus_u.err), (wl_plane >= 0) ? 1 : 0);
    cyc(chain, 1'b0, 1'b0, '0);
    check({tag, " out_valid one cycle"}, int'(bus_u.out_valid), 0);
    if (chain) begin
      check({tag, " chained busy"}, int'(bus_u.busy), 1);
      check({tag, " chained acc cleared"}, acc_u(), 0);
    end else begin
      check({tag, " acc held"}, acc_u(), exp_u);
    end
  endtask

  logic [NC-1:0] pa [IB];
  logic [NC-1:0] pf [IB];

  initial begin
    pa = '{16'h0007, 16'h0000, 16'hFFFF, 16'h8000};
    pf = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    bus_u.start = 1'b0; bus_u.in_valid = 1'b0; bus_u.wl = 1'b0; bus_u.vout = '0;
    repeat (2) @(negedge clk);
    check("reset busy", int'(bus_u.busy), 0);
    check("reset out_valid", int'(bus_u.out_valid), 0);
    check("reset acc", acc_u(), 0);
    check("reset err", int'(bus_u.err), 0);
    rst = 1'b0;

    // in_valid in IDLE is ignored
    cyc(1'b0, 1'b1, 1'b0, 16'hFFFF);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("idle ignores planes", acc_u(), 0);
    check("idle not busy", int'(bus_u.busy), 0);

    run_op("basic",   pa, 0, -1, -1, 1'b0, 1'b0, 57, 9);
    run_op("all_ones", pf, 0, -1, -1, 1'b0, 1'b0, 240, -16);
    run_op("gapped",  pa, 2, -1, -1, 1'b0, 1'b0, 57, 9);
    run_op("wl_coll", pa, 0, 2, -1, 1'b0, 1'b0, 57, 9);
    run_op("err_clr", pa, 0, -1, -1, 1'b0, 1'b0, 57, 9);
    run_op("busy_st", pa, 0, -1, 2, 1'b0, 1'b0, 57, 9);
    run_op("chain_a", pa, 0, -1, -1, 1'b0, 1'b1, 57, 9);
    run_op("chain_b", pf, 0, -1, -1, 1'b1, 1'b0, 240, -16);

    // Reset mid-operation after two planes
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, pa[0]);
    cyc(1'b0, 1'b1, 1'b0, pa[1]);
    check("mid acc unsigned", acc_u(), 3);
    check("mid acc signed", acc_s(), -3);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", int'(bus_u.busy), 0);
    check("async rst acc u", acc_u(), 0);
    check("async rst acc s", acc_s(), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, pa[i]);
      check("no out_valid after abort", int'(bus_u.out_valid), 0);
      check("idle after abort", int'(bus_u.busy), 0);
    end
    run_op("post_rst", pa, 0, -1, -1, 1'b0, 1'b0, 57, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
